// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer: ALU op codes, FSM states,
// instruction field positions and the legal-opcode check.
package instr_sequencer_pkg;

  localparam logic [6:0] OP_ADD = 7'h01;
  localparam logic [6:0] OP_SUB = 7'h02;
  localparam logic [6:0] OP_AND = 7'h03;
  localparam logic [6:0] OP_OR  = 7'h04;
  localparam logic [6:0] OP_XOR = 7'h05;
  localparam logic [6:0] OP_SLT = 7'h06;
  localparam logic [6:0] OP_SLL = 7'h07;
  localparam logic [6:0] OP_SRL = 7'h08;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 25;
  localparam int unsigned RD_MSB  = 24;
  localparam int unsigned RD_LSB  = 20;
  localparam int unsigned RS1_MSB = 19;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned IBIT    = 14;
  localparam int unsigned RS2_MSB = 13;
  localparam int unsigned RS2_LSB = 9;
  localparam int unsigned IMM_MSB = 13;

  function automatic logic is_legal_op(input logic [6:0] opc);
    logic legal;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SLT, OP_SLL, OP_SRL: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field decode of one 32-bit instruction word into DataPath
// controls plus a legal-opcode flag.
module instr_field_decode
  import instr_sequencer_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [6:0]  o_op,
  output logic [4:0]  o_addr_a,
  output logic [4:0]  o_addr_b,
  output logic [4:0]  o_addr_d,
  output logic [31:0] o_immed,
  output logic        o_y_sel,
  output logic        o_legal
);

  logic w_ibit;

  assign w_ibit = i_instr[IBIT];

  always_comb begin
    o_op     = i_instr[OPC_MSB:OPC_LSB];
    o_addr_d = i_instr[RD_MSB:RD_LSB];
    o_addr_a = i_instr[RS1_MSB:RS1_LSB];
    o_legal  = is_legal_op(i_instr[OPC_MSB:OPC_LSB]);
    o_y_sel  = w_ibit;
    o_addr_b = '0;
    o_immed  = '0;
    if (w_ibit) begin
      o_immed = {{(31 - IMM_MSB){i_instr[IMM_MSB]}}, i_instr[IMM_MSB:0]};
    end else begin
      o_addr_b = i_instr[RS2_MSB:RS2_LSB];
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: accepts a word in IDLE or WB, then steps
// DECODE -> EXEC -> WB, pulsing write (or illegal) in WB.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [6:0]       op,
  output logic [4:0]       addr_a,
  output logic [4:0]       addr_b,
  output logic [4:0]       addr_d,
  output logic [31:0]      immed,
  output logic             y_sel,
  output logic             write,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t r_state;
  state_t w_next;
  logic   w_accept;

  logic [6:0]       w_op;
  logic [4:0]       w_addr_a;
  logic [4:0]       w_addr_b;
  logic [4:0]       w_addr_d;
  logic [31:0]      w_immed;
  logic             w_y_sel;
  logic             w_legal;

  logic [6:0]       r_op;
  logic [4:0]       r_addr_a;
  logic [4:0]       r_addr_b;
  logic [4:0]       r_addr_d;
  logic [31:0]      r_immed;
  logic             r_y_sel;
  logic             r_legal;
  logic             r_write;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  instr_field_decode u_decode (
    .i_instr  (instr),
    .o_op     (w_op),
    .o_addr_a (w_addr_a),
    .o_addr_b (w_addr_b),
    .o_addr_d (w_addr_d),
    .o_immed  (w_immed),
    .o_y_sel  (w_y_sel),
    .o_legal  (w_legal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Ready depends on state alone; instr_valid only steers the next state.
  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = ST_DECODE;
      end
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC:   w_next = ST_WB;
      ST_WB: begin
        instr_ready = 1'b1;
        w_next      = instr_valid ? ST_DECODE : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    w_accept = instr_ready & instr_valid;
  end

  // write/illegal are registered on the EXEC->WB edge so they occupy exactly
  // the WB cycle; retire uses the outgoing r_legal even when WB reloads fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_addr_a  <= '0;
      r_addr_b  <= '0;
      r_addr_d  <= '0;
      r_immed   <= '0;
      r_y_sel   <= 1'b0;
      r_legal   <= 1'b0;
      r_write   <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= w_op;
        r_addr_a <= w_addr_a;
        r_addr_b <= w_addr_b;
        r_addr_d <= w_addr_d;
        r_immed  <= w_immed;
        r_y_sel  <= w_y_sel;
        r_legal  <= w_legal;
      end
      r_write   <= (r_state == ST_EXEC) &&  r_legal;
      r_illegal <= (r_state == ST_EXEC) && !r_legal;
      if ((r_state == ST_WB) && r_legal) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign op      = r_op;
  assign addr_a  = r_addr_a;
  assign addr_b  = r_addr_b;
  assign addr_d  = r_addr_d;
  assign immed   = r_immed;
  assign y_sel   = r_y_sel;
  assign write   = r_write;
  assign illegal = r_illegal;
  assign retired = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; a second instance with a
// 2-bit counter shares the stimulus to exercise retired wrap-around.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;

  logic        instr_ready, y_sel, write, illegal;
  logic [6:0]  op;
  logic [4:0]  addr_a, addr_b, addr_d;
  logic [31:0] immed;
  logic [15:0] retired;

  logic        instr_ready2, y_sel2, write2, illegal2;
  logic [6:0]  op2;
  logic [4:0]  addr_a2, addr_b2, addr_d2;
  logic [31:0] immed2;
  logic [1:0]  retired2;

  int n_cmp = 0;
  int n_err = 0;

  instr_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .op(op), .addr_a(addr_a), .addr_b(addr_b),
    .addr_d(addr_d), .immed(immed), .y_sel(y_sel), .write(write),
    .illegal(illegal), .retired(retired)
  );

  instr_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready2), .op(op2), .addr_a(addr_a2), .addr_b(addr_b2),
    .addr_d(addr_d2), .immed(immed2), .y_sel(y_sel2), .write(write2),
    .illegal(illegal2), .retired(retired2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic ib,
                                     input logic [13:0] low);
    return {opc, rd, rs1, ib, low};
  endfunction

  // Presents one word from IDLE and records the five cycles after acceptance.
  task automatic issue(input logic [31:0] w, output logic [5:1] wr,
                       output logic [5:1] il, output logic [5:1] rdy,
                       output logic [54:0] ctl1, output logic [54:0] ctl3,
                       output logic [57:0] all2_3);
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      wr[k]  = write;
      il[k]  = illegal;
      rdy[k] = instr_ready;
      if (k == 1) ctl1 = {op, addr_a, addr_b, addr_d, immed, y_sel};
      if (k == 3) begin
        ctl3   = {op, addr_a, addr_b, addr_d, immed, y_sel};
        all2_3 = {op2, addr_a2, addr_b2, addr_d2, immed2, y_sel2,
                  instr_ready2, write2, illegal2};
      end
    end
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({op, addr_a, addr_b, addr_d, immed, y_sel, write, illegal, retired} !== '0) begin
      n_err++;
      $display("FAIL rst_outputs: got op=%h a=%h b=%h d=%h imm=%h ysel=%b wr=%b ill=%b ret=%0d want all 0",
               op, addr_a, addr_b, addr_d, immed, y_sel, write, illegal, retired);
    end
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_ready_low: got %b want 1", instr_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({instr_ready, retired, retired2, write} !== {1'b1, 16'd0, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_release: got rdy=%b ret=%0d ret2=%0d wr=%b want 1/0/0/0",
               instr_ready, retired, retired2, write);
    end
  endtask

  task automatic test_add;
    logic [5:1] wr, il, rdy;
    logic [54:0] c1, c3, exp;
    logic [57:0] a2;
    exp = {OP_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0};
    issue(mk(OP_ADD, 5'd3, 5'd1, 1'b0, {5'd2, 9'd0}), wr, il, rdy, c1, c3, a2);
    n_cmp++;
    if (c1 !== exp) begin n_err++; $display("FAIL add_decode: got %h want %h", c1, exp); end
    n_cmp++;
    if (c3 !== exp) begin n_err++; $display("FAIL add_held: got %h want %h", c3, exp); end
    n_cmp++;
    if (wr !== 5'b00100) begin n_err++; $display("FAIL add_write: got %b want 00100", wr); end
    n_cmp++;
    if (rdy !== 5'b11100) begin n_err++; $display("FAIL add_ready: got %b want 11100", rdy); end
    n_cmp++;
    if (il !== 5'b00000) begin n_err++; $display("FAIL add_illegal: got %b want 00000", il); end
    n_cmp++;
    if (retired !== 16'd1) begin n_err++; $display("FAIL add_retired: got %0d want 1", retired); end
    n_cmp++;
    if (a2 !== {exp, 3'b110}) begin
      n_err++; $display("FAIL add_dut2_wb: got %h want %h", a2, {exp, 3'b110});
    end
  endtask

  task automatic test_imm;
    logic [5:1] wr, il, rdy;
    logic [54:0] c1, c3, exp;
    logic [57:0] a2;
    exp = {OP_ADD, 5'd0, 5'd0, 5'd5, 32'hFFFF_FFFF, 1'b1};
    issue(mk(OP_ADD, 5'd5, 5'd0, 1'b1, 14'h3FFF), wr, il, rdy, c1, c3, a2);
    n_cmp++;
    if (c1 !== exp) begin n_err++; $display("FAIL imm_decode: got %h want %h", c1, exp); end
    n_cmp++;
    if (wr !== 5'b00100) begin n_err++; $display("FAIL imm_write: got %b want 00100", wr); end
    n_cmp++;
    if (retired !== 16'd2) begin n_err++; $display("FAIL imm_retired: got %0d want 2", retired); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [4];
    logic [6:0]  eop [4];
    logic [4:0]  erd [4];
    logic [13:1] wr, rdy;
    w[0] = mk(OP_SUB, 5'd4, 5'd1, 1'b0, {5'd2, 9'd0});
    w[1] = mk(OP_XOR, 5'd6, 5'd2, 1'b1, 14'h0010);
    w[2] = mk(OP_SLL, 5'd7, 5'd3, 1'b0, {5'd9, 9'd0});
    w[3] = mk(OP_SRL, 5'd0, 5'd4, 1'b0, {5'd1, 9'd0});
    eop[0] = OP_SUB; eop[1] = OP_XOR; eop[2] = OP_SLL; eop[3] = OP_SRL;
    erd[0] = 5'd4;   erd[1] = 5'd6;   erd[2] = 5'd7;   erd[3] = 5'd0;
    instr       = w[0];
    instr_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      wr[k]  = write;
      rdy[k] = instr_ready;
      if (k == 1 || k == 4 || k == 7 || k == 10) begin
        n_cmp++;
        if (op !== eop[(k-1)/3]) begin
          n_err++; $display("FAIL b2b_op[%0d]: got %h want %h", k, op, eop[(k-1)/3]);
        end
      end
      if (k == 3 || k == 6 || k == 9 || k == 12) begin
        n_cmp++;
        if (addr_d !== erd[k/3-1]) begin
          n_err++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", k, addr_d, erd[k/3-1]);
        end
      end
      if (k == 1) instr = w[1];
      if (k == 4) instr = w[2];
      if (k == 7) instr = w[3];
      if (k == 10) instr_valid = 1'b0;
    end
    n_cmp++;
    if (wr !== 13'b0_1001_0010_0100) begin
      n_err++; $display("FAIL b2b_write: got %b want 0100100100100", wr);
    end
    n_cmp++;
    if (rdy !== 13'b1_1001_0010_0100) begin
      n_err++; $display("FAIL b2b_ready: got %b want 1100100100100", rdy);
    end
    n_cmp++;
    if (retired !== 16'd6) begin n_err++; $display("FAIL b2b_retired: got %0d want 6", retired); end
  endtask

  task automatic test_illegal;
    logic [5:1] wr, il, rdy;
    logic [54:0] c1, c3;
    logic [57:0] a2;
    issue(mk(7'h7F, 5'd2, 5'd3, 1'b0, {5'd4, 9'd0}), wr, il, rdy, c1, c3, a2);
    n_cmp++;
    if (il !== 5'b00100) begin n_err++; $display("FAIL ill_pulse: got %b want 00100", il); end
    n_cmp++;
    if (wr !== 5'b00000) begin n_err++; $display("FAIL ill_write: got %b want 00000", wr); end
    n_cmp++;
    if (c1[54:48] !== 7'h7F) begin n_err++; $display("FAIL ill_op: got %h want 7f", c1[54:48]); end
    n_cmp++;
    if ({retired, retired2} !== {16'd6, 2'd2}) begin
      n_err++; $display("FAIL ill_retired: got %0d/%0d want 6/2", retired, retired2);
    end
  endtask

  task automatic test_reset_exec_and_wrap;
    logic wr_seen;
    logic [5:1] wr, il, rdy;
    logic [54:0] c1, c3;
    logic [57:0] a2;
    instr       = mk(OP_AND, 5'd8, 5'd1, 1'b0, {5'd2, 9'd0});
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({instr_ready, write, retired, retired2} !== {1'b1, 1'b0, 16'd0, 2'd0}) begin
      n_err++;
      $display("FAIL rstx_abort: got rdy=%b wr=%b ret=%0d ret2=%0d want 1/0/0/0",
               instr_ready, write, retired, retired2);
    end
    wr_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      wr_seen = wr_seen | write;
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      wr_seen = wr_seen | write;
    end
    n_cmp++;
    if (wr_seen !== 1'b0) begin n_err++; $display("FAIL rstx_nowrite: got %b want 0", wr_seen); end
    for (int j = 0; j < 5; j++) begin
      issue(mk(OP_OR, 5'(j), 5'd1, 1'b0, {5'd2, 9'd0}), wr, il, rdy, c1, c3, a2);
    end
    n_cmp++;
    if (retired !== 16'd5) begin n_err++; $display("FAIL wrap_ret16: got %0d want 5", retired); end
    n_cmp++;
    if (retired2 !== 2'd1) begin n_err++; $display("FAIL wrap_ret2: got %0d want 1", retired2); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm();
    test_back_to_back();
    test_illegal();
    test_reset_exec_and_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
